// File: rtl/count_sequencer.sv
// rtl/count_sequencer.sv - FSM-controlled tick divider and up/down run counter
module count_sequencer #(
  parameter int FREQ    = 50000000,
  parameter int TICK_HZ = 1,
  parameter int WIDTH   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             clear,
  input  logic             up,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             running,
  output logic             done
);

  localparam int DIV = FREQ / TICK_HZ;
  localparam int DW  = $clog2(DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t           state, state_n;
  logic [DW-1:0]    div_cnt, div_cnt_n;
  logic [WIDTH-1:0] count_n;
  logic [WIDTH-1:0] limit_q, limit_n;
  logic [WIDTH-1:0] step_val, terminal;
  logic             up_q, up_n;
  logic             tick_n;

  assign terminal = up_q ? limit_q : '0;
  assign step_val = up_q ? count + WIDTH'(1) : count - WIDTH'(1);

  assign running = (state == RUN);
  assign done    = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      div_cnt <= '0;
      tick    <= 1'b0;
      up_q    <= 1'b0;
      limit_q <= '0;
    end else begin
      state   <= state_n;
      count   <= count_n;
      div_cnt <= div_cnt_n;
      tick    <= tick_n;
      up_q    <= up_n;
      limit_q <= limit_n;
    end
  end

  always_comb begin
    state_n   = state;
    count_n   = count;
    div_cnt_n = div_cnt;
    tick_n    = 1'b0;
    up_n      = up_q;
    limit_n   = limit_q;

    if (clear) begin
      state_n   = IDLE;
      count_n   = '0;
      div_cnt_n = '0;
    end else if (pause) begin
      // pause outranks start everywhere; it only changes state when running
      if (state == RUN) begin
        state_n = PAUSE;
      end
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            up_n      = up;
            limit_n   = limit;
            count_n   = up ? '0 : limit;
            div_cnt_n = '0;
            // both directions load a terminal value when limit is zero
            state_n   = (limit == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt_n = '0;
            count_n   = step_val;
            tick_n    = 1'b1;
            if (step_val == terminal) begin
              state_n = DONE;
            end
          end else begin
            div_cnt_n = div_cnt + DW'(1);
          end
        end
        PAUSE: begin
          // resume keeps the held divider phase
          if (start) begin
            state_n = RUN;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_count_sequencer.sv
// tb/tb_count_sequencer.sv - scoreboard bench for count_sequencer with a tick-schedule model
module tb_count_sequencer;

  localparam int DIV = 10;
  localparam int W   = 4;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         pause;
  logic         clear;
  logic         up;
  logic [W-1:0] limit;
  logic [W-1:0] count;
  logic         tick;
  logic         running;
  logic         done;

  count_sequencer #(.FREQ(10), .TICK_HZ(1), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .clear(clear),
    .up(up), .limit(limit), .count(count), .tick(tick),
    .running(running), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    logic [W-1:0] val;
  } tick_t;

  tick_t        exp_q[$];
  int           cyc        = 0;
  int           mode       = M_IDLE;
  int           last_edge  = 0;
  int           pause_edge = 0;
  logic [W-1:0] exp_cnt    = '0;
  bit           mon_en     = 1'b0;
  int           checks     = 0;
  int           errors     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Model: a run is a schedule of future tick edges; pausing shifts the remainder.
  task automatic model_edge(input bit s, input bit p, input bit c, input bit r,
                            input bit u, input logic [W-1:0] l);
    int e;
    int eff;
    int shift;
    tick_t t;
    e   = cyc;
    eff = mode;
    if (mode == M_RUN && last_edge < e) eff = M_DONE;
    if (r || c) begin
      exp_q.delete();
      mode    = M_IDLE;
      exp_cnt = '0;
    end else if (p) begin
      if (eff == M_RUN) begin
        mode       = M_PAUSE;
        pause_edge = e;
      end else begin
        mode = eff;
      end
    end else if (s && (eff == M_IDLE || eff == M_DONE)) begin
      exp_cnt   = u ? '0 : l;
      mode      = M_RUN;
      last_edge = e + DIV * int'(l);
      for (int k = 1; k <= int'(l); k++) begin
        t.cyc = e + DIV * k;
        t.val = u ? W'(k) : l - W'(k);
        exp_q.push_back(t);
      end
    end else if (s && eff == M_PAUSE) begin
      shift = e - pause_edge + 1;
      for (int i = 0; i < exp_q.size(); i++) begin
        t = exp_q[i];
        t.cyc += shift;
        exp_q[i] = t;
      end
      last_edge += shift;
      mode = M_RUN;
    end else begin
      mode = eff;
    end
  endtask

  always @(negedge clk) begin
    int    exp_run;
    int    exp_done;
    tick_t t;
    if (mon_en) begin
      exp_run  = (mode == M_RUN && last_edge > cyc) ? 1 : 0;
      exp_done = (mode == M_DONE || (mode == M_RUN && last_edge <= cyc)) ? 1 : 0;
      if (tick) begin
        if (mode == M_PAUSE || exp_q.size() == 0) begin
          chk("unexpected_tick", int'(tick), 0);
        end else begin
          t = exp_q.pop_front();
          chk("tick_cycle", cyc, t.cyc);
          chk("tick_count", int'(count), int'(t.val));
          exp_cnt = t.val;
        end
      end else if (mode != M_PAUSE && exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        t = exp_q.pop_front();
        chk("missing_tick", int'(tick), 1);
        exp_cnt = t.val;
      end
      chk("count", int'(count), int'(exp_cnt));
      chk("running", int'(running), exp_run);
      chk("done", int'(done), exp_done);
    end
  end

  task automatic step(input bit s, input bit p, input bit c, input bit r,
                      input bit u, input logic [W-1:0] l);
    start = s; pause = p; clear = c; rst = r; up = u; limit = l;
    @(posedge clk);
    #1;
    model_edge(s, p, c, r, u, l);
  endtask

  // Idle cycles scramble up/limit to show they only matter when start is sampled.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom), W'($urandom));
  endtask

  initial begin
    int rv;
    start = 1'b0; pause = 1'b0; clear = 1'b0; rst = 1'b1; up = 1'b0; limit = '0;

    step(1, 0, 0, 1, 1, 4'd5);
    mon_en = 1'b1;
    step(1, 0, 0, 1, 1, 4'd5);
    idle(5);

    step(1, 0, 0, 0, 1, 4'd3);
    idle(85);

    step(1, 0, 0, 0, 0, 4'd2);
    idle(25);

    step(1, 0, 0, 0, 1, 4'd5);
    idle(14);
    repeat (20) step(0, 1, 0, 0, 1, 4'd9);
    step(1, 0, 0, 0, 0, 4'd1);
    idle(10);
    step(0, 0, 1, 0, 0, 4'd0);

    step(1, 0, 0, 0, 1, 4'd5);
    idle(24);
    step(1, 1, 1, 0, 0, 4'd7);
    idle(3);
    step(1, 0, 0, 0, 1, 4'd5);
    idle(24);
    step(1, 1, 0, 1, 0, 4'd7);
    idle(3);

    step(1, 0, 0, 0, 1, 4'd0);
    idle(5);
    step(1, 0, 0, 0, 0, 4'd0);
    idle(5);

    step(1, 0, 0, 0, 1, 4'd4);
    idle(19);
    step(0, 1, 0, 0, 1, 4'd4);
    idle(5);
    step(1, 0, 0, 0, 1, 4'd4);
    idle(5);
    step(0, 0, 1, 0, 1, 4'd4);

    for (int i = 0; i < 1500; i++) begin
      rv = int'($urandom_range(0, 99));
      step(rv < 8, rv >= 8 && rv < 13, rv == 13, rv == 14, 1'($urandom), W'($urandom));
    end

    step(0, 0, 1, 0, 0, 4'd0);
    idle(2);
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_sequencer.md
# count_sequencer

Run-control sequencer for the counter datapath: it divides the system clock down to a programmable tick rate and steps a WIDTH-bit counter up or down toward a latched limit. It handles start, pause, resume and clear requests from debounced buttons or a host. It sits between the board clock/buttons and the display/counter logic, and replaces free-running divider-plus-counter pairs with one FSM-controlled block.

## Interface
- FREQ, 50000000, input clock frequency in Hz
- TICK_HZ, 1, count-step rate in Hz. The internal divide ratio is DIV = FREQ/TICK_HZ, which must be an integer ≥ 2.
- WIDTH, 8, counter and limit width in bits
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  level-sampled request to begin a run or resume from pause
- pause  in  1  level-sampled request to suspend counting
- clear  in  1  level-sampled request to abort and return to idle
- up  in  1  direction, latched on start: 1 counts up 0→limit, 0 counts down limit→0
- limit  in  WIDTH  terminal value, latched on start
- count  out  WIDTH  current count value (registered)
- tick  out  1  one-cycle pulse in the cycle each new count value first appears
- running  out  1  high while in RUN
- done  out  1  high while in DONE

## Operation
- Internal divider: $clog2(DIV)-bit counter `div_cnt`.
  - In RUN it advances 0..DIV-1 and wraps.
  - In PAUSE it holds its value.
  - In IDLE it is held at 0, and on entry to RUN from IDLE or DONE it is reset to 0.
- FSM states: IDLE, RUN, PAUSE, DONE. All outputs are registered.
- Input priority is rst > clear > pause > start. This applies in every state.
- IDLE:
  - count = 0.
  - When start is sampled: latch up and limit, load count (0 if up=1, limit if up=0), and enter RUN.
  - Exception: if the loaded value is already terminal (up=1 and limit=0, or up=0 and limit=0), go directly to DONE.
- RUN:
  - On the cycle div_cnt = DIV-1, step count by ±1 and pulse tick.
  - If the new value equals the terminal value (limit when counting up, 0 when counting down), go to DONE.
  - pause goes to PAUSE. A pause sampled on the same cycle as div_cnt = DIV-1 wins: no step and no tick, and div_cnt stays at DIV-1.
- PAUSE:
  - count and div_cnt are held.
  - start returns to RUN with div_cnt continuing from its held value, not reset.
  - pause has no effect.
- DONE:
  - count is held at the terminal value and no ticks are issued.
  - start restarts: relatch up and limit, reload count, reset div_cnt, enter RUN (same terminal-limit exception as IDLE).
- clear in any state: next cycle is IDLE, count=0, div_cnt=0, tick=0.
- Changes to up or limit outside the start-sampling cycle have no effect.
- count never wraps: the terminal check stops counting at limit or 0.

## Timing
- Reset values: count=0, tick=0, running=0, done=0, state IDLE, div_cnt=0.
- Let start be sampled at edge E0:
  - running=1 and the loaded count are visible after E0.
  - The first step, with tick=1, is visible after edge E0+DIV.
  - Later steps follow every DIV cycles.
- Resume from pause: if div_cnt held value v, the next tick appears DIV-v cycles after the resuming start edge.
- DONE entry: done=1 and running=0 in the same cycle as the final tick.
- clear, pause and the start transition each take effect one cycle after sampling. No combinational input-to-output paths.
- rst asserted mid-run: all state returns to reset values after the next edge, regardless of other inputs.

## Test plan
Bench parameters: FREQ=10, TICK_HZ=1 (DIV=10), WIDTH=4, clock period 10 ns.
- Reset: rst=1 for 2 cycles with start=1 → count=0, running=0, done=0, tick=0; stays IDLE after release until a fresh start is sampled.
- Up run: limit=3, up=1, 1-cycle start → count 1, 2, 3 at 10, 20, 30 cycles after start, each with a 1-cycle tick; done=1 and running=0 with count=3; no further ticks for 50 cycles.
- Down run: limit=2, up=0, start → count=2 next cycle; 1 at +10, 0 at +20, then done=1.
- Pause/resume: limit=5, up=1, start; pause at +14 cycles (div_cnt=4), held 20 cycles → count stays 1, no tick; start → tick and count=2 exactly 6 cycles later.
- Priority/abort:
  - clear, pause and start all high in the same cycle during RUN (count=2) → IDLE, count=0, running=0 next cycle.
  - Repeat with rst instead of clear → same result.
- Boundary: limit=0, up=1, start → DONE next cycle with count=0, done=1, no tick. Separately, pause on the exact DIV-1 cycle → no step, and count advances 1 cycle after resume.
